// File: rtl/serial_2of5_tx.sv
// Transmit side of the 2-of-5 digit link: BCD digit in over valid/ready,
// 7-4-2-1-0 encoded word out as a framed serial stream (start, 5 data, stop).
module serial_2of5_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic [4:0] code_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         idx_q;
   logic [4:0]         shift_q;
   logic [4:0]         code_q;
   logic               tx_q;
   logic               done_q;
   logic               err_q;

   logic               bit_end;
   logic               digit_ok;
   logic [4:0]         enc_word;

   // Word order {w7,w4,w2,w1,w0}; zero uses 7+4 since 11 cannot occur in BCD.
   always_comb begin
      enc_word = 5'b00000;
      unique case (digit_i)
         4'd0:    enc_word = 5'b11000;
         4'd1:    enc_word = 5'b00011;
         4'd2:    enc_word = 5'b00101;
         4'd3:    enc_word = 5'b00110;
         4'd4:    enc_word = 5'b01001;
         4'd5:    enc_word = 5'b01010;
         4'd6:    enc_word = 5'b01100;
         4'd7:    enc_word = 5'b10001;
         4'd8:    enc_word = 5'b10010;
         4'd9:    enc_word = 5'b10100;
         default: enc_word = 5'b00000;
      endcase
   end

   assign digit_ok = (digit_i <= 4'd9);
   assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 5'b00000;
         code_q  <= 5'b00000;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  if (digit_ok) begin
                     code_q  <= enc_word;
                     shift_q <= enc_word;
                     tx_q    <= 1'b0;
                     cnt_q   <= '0;
                     idx_q   <= 3'd0;
                     state_q <= StStart;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StStart: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  idx_q   <= 3'd0;
                  tx_q    <= shift_q[4];
                  shift_q <= {shift_q[3:0], 1'b0};
                  state_q <= StData;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StData: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd4) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     tx_q    <= shift_q[4];
                     shift_q <= {shift_q[3:0], 1'b0};
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  idx_q   <= 3'd0;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o = (state_q == StIdle);
   assign busy_o  = (state_q != StIdle);
   assign tx_o    = tx_q;
   assign code_o  = code_q;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_serial_2of5_tx.sv
// Directed self-checking bench for serial_2of5_tx with CLKS_PER_BIT=4.
module tb_serial_2of5_tx;

   logic       clk;
   logic       rst_n;
   logic [3:0] digit_i;
   logic       valid_i;
   logic       ready_o;
   logic       tx_o;
   logic [4:0] code_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   int checks;
   int failures;

   logic [4:0] exp_code [10];

   serial_2of5_tx #(
      .CLKS_PER_BIT(4),
      .CNT_W       (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .digit_i(digit_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .tx_o   (tx_o),
      .code_o (code_o),
      .busy_o (busy_o),
      .done_o (done_o),
      .err_o  (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int popcnt5(input logic [4:0] w);
      int c;
      c = 0;
      for (int i = 0; i < 5; i++) c += int'(w[i]);
      return c;
   endfunction

   function automatic int decode5(input logic [4:0] w);
      if (w == 5'b11000) return 0;
      return 7 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]);
   endfunction

   // Called right after the transfer edge (n=0); samples each 4-cycle slot at
   // its second cycle and stops on the cycle where done_o is seen.
   task automatic capture_frame(input bit toggle, output logic [6:0] slots,
                                output int done_n, output int dones);
      int n;
      slots  = 7'b1111111;
      done_n = -1;
      dones  = 0;
      n      = 0;
      while (n <= 40) begin
         if (n > 0) tick();
         if ((n % 4) == 1 && (n / 4) < 7) slots[6 - n / 4] = tx_o;
         if (done_o) begin
            dones++;
            done_n = n;
            break;
         end
         if (toggle) begin
            digit_i = 4'd9;
            valid_i = (n < 20) ? n[0] : 1'b0;
         end
         n++;
      end
   endtask

   task automatic check_frame(input string name, input logic [6:0] slots,
                              input logic [6:0] exp_slots, input int done_n);
      checks++;
      if (slots !== exp_slots) begin
         failures++;
         $display("FAIL %s slots: got %b expected %b", name, slots, exp_slots);
      end
      checks++;
      if (done_n !== 28) begin
         failures++;
         $display("FAIL %s done_cycle: got %0d expected 28", name, done_n);
      end
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL %s ready_at_done: got ready=%b busy=%b expected ready=1 busy=0",
                  name, ready_o, busy_o);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      valid_i = 1'b0;
      digit_i = 4'd0;
      tick();
      tick();
      checks++;
      if ({tx_o, ready_o, busy_o, done_o, err_o, code_o} !== 10'b1_1_0_0_0_00000) begin
         failures++;
         $display("FAIL reset_state: got tx=%b rdy=%b busy=%b done=%b err=%b code=%b",
                  tx_o, ready_o, busy_o, done_o, err_o, code_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_midframe();
      int seen_done;
      digit_i = 4'd5;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx_o !== 1'b1 || ready_o !== 1'b1 || code_o !== 5'b00000 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_midframe: got tx=%b rdy=%b busy=%b code=%b expected 1 1 0 00000",
                  tx_o, ready_o, busy_o, code_o);
      end
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done_o) seen_done++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done_o || tx_o !== 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         failures++;
         $display("FAIL reset_no_done: got %0d done/low-tx cycles expected 0", seen_done);
      end
   endtask

   task automatic test_single_digit0();
      logic [6:0] slots;
      int         dn;
      int         dc;
      digit_i = 4'd0;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      digit_i = 4'd6;
      capture_frame(1'b0, slots, dn, dc);
      check_frame("digit0", slots, 7'b0110001, dn);
      checks++;
      if (code_o !== 5'b11000) begin
         failures++;
         $display("FAIL digit0_code: got %b expected 11000", code_o);
      end
   endtask

   task automatic test_all_digits();
      logic [6:0] slots;
      logic [4:0] word;
      int         dn;
      int         dc;
      for (int d = 0; d < 10; d++) begin
         digit_i = 4'(d);
         valid_i = 1'b1;
         tick();
         valid_i = 1'b0;
         capture_frame(1'b0, slots, dn, dc);
         word = slots[5:1];
         checks++;
         if (slots[6] !== 1'b0 || slots[0] !== 1'b1 || word !== exp_code[d] || dn != 28) begin
            failures++;
            $display("FAIL all_digits_frame d=%0d: got frame %b done=%0d expected %b done=28",
                     d, slots, dn, {1'b0, exp_code[d], 1'b1});
         end
         checks++;
         if (popcnt5(word) != 2 || decode5(word) != d) begin
            failures++;
            $display("FAIL all_digits_decode d=%0d: got popcount %0d decoded %0d expected 2 %0d",
                     d, popcnt5(word), decode5(word), d);
         end
         checks++;
         if (code_o !== exp_code[d]) begin
            failures++;
            $display("FAIL all_digits_code d=%0d: got %b expected %b", d, code_o, exp_code[d]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [6:0] slots;
      int         dn;
      int         dc;
      // code_o still holds digit 9 from the previous test
      digit_i = 4'd12;
      valid_i = 1'b1;
      tick();
      checks++;
      if (err_o !== 1'b1 || tx_o !== 1'b1 || ready_o !== 1'b1 || code_o !== 5'b10100) begin
         failures++;
         $display("FAIL illegal_reject: got err=%b tx=%b rdy=%b code=%b expected 1 1 1 10100",
                  err_o, tx_o, ready_o, code_o);
      end
      digit_i = 4'd7;
      tick();
      valid_i = 1'b0;
      checks++;
      if (err_o !== 1'b0) begin
         failures++;
         $display("FAIL illegal_err_pulse: got err=%b expected 0", err_o);
      end
      capture_frame(1'b0, slots, dn, dc);
      check_frame("after_illegal7", slots, 7'b0100011, dn);
   endtask

   task automatic test_back_to_back();
      logic [6:0] slots;
      int         dn;
      int         dc;
      digit_i = 4'd3;
      valid_i = 1'b1;
      tick();
      digit_i = 4'd8;
      capture_frame(1'b0, slots, dn, dc);
      check_frame("b2b_3", slots, 7'b0001101, dn);
      tick();
      valid_i = 1'b0;
      checks++;
      if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_contiguous: got tx=%b busy=%b expected tx=0 busy=1", tx_o, busy_o);
      end
      capture_frame(1'b0, slots, dn, dc);
      check_frame("b2b_8", slots, 7'b0100101, dn);
   endtask

   task automatic test_busy_protect();
      logic [6:0] slots;
      int         dn;
      int         dc;
      digit_i = 4'd1;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      capture_frame(1'b1, slots, dn, dc);
      check_frame("busy_protect1", slots, 7'b0000111, dn);
      valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_o || busy_o) dc++;
      end
      checks++;
      if (dc != 1 || code_o !== 5'b00011) begin
         failures++;
         $display("FAIL busy_single_done: got %0d events code=%b expected 1 00011", dc, code_o);
      end
   endtask

   initial begin
      exp_code[0] = 5'b11000; exp_code[1] = 5'b00011; exp_code[2] = 5'b00101;
      exp_code[3] = 5'b00110; exp_code[4] = 5'b01001; exp_code[5] = 5'b01010;
      exp_code[6] = 5'b01100; exp_code[7] = 5'b10001; exp_code[8] = 5'b10010;
      exp_code[9] = 5'b10100;
      checks   = 0;
      failures = 0;
      test_reset();
      test_reset_midframe();
      test_single_digit0();
      test_all_digits();
      test_illegal();
      test_back_to_back();
      test_busy_protect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_2of5_tx.md
Name: serial_2of5_tx

Overview:
- Transmit side of the 2-of-5 digit link.
- Accepts a BCD digit over a valid/ready handshake and encodes it to a 2-of-5 code word using weights 7-4-2-1-0.
- Shifts the word out on a single serial line as a framed bit stream: start bit, 5 data bits, stop bit.
- The receiving end checks the word for exactly two ones and drives the 5x7 matrix rows. This block guarantees it only ever sends valid words.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit time; legal range 2..255.
- CNT_W, 8, width of the bit-time counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digit_i  input  4  BCD digit to send.
- valid_i  input  1  digit_i is valid.
- ready_o  output  1  block can accept a digit.
- tx_o  output  1  serial line; idles high.
- code_o  output  5  last encoded word, bit order {w7,w4,w2,w1,w0}, for local echo.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse at end of frame.
- err_o  output  1  one-cycle pulse when an illegal digit (10..15) is rejected.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - tx_o=1, ready_o=1, busy_o=0, done_o=0, err_o=0, code_o=5'b00000.
  - State=IDLE, bit counter=0, bit index=0.
- Reset mid-frame aborts immediately. tx_o returns high with no stop bit, and no done_o pulse is produced.
- Encoding table {w7,w4,w2,w1,w0}:
  - 0=11000, 1=00011, 2=00101, 3=00110, 4=01001
  - 5=01010, 6=01100, 7=10001, 8=10010, 9=10100
- Handshake:
  - A transfer occurs on a rising edge where valid_i=1 and ready_o=1.
  - ready_o=1 only in IDLE.
  - digit_i is sampled only at the transfer edge and may change afterwards.
- Illegal digit (10..15) at transfer:
  - No frame is sent; state stays IDLE and tx_o stays 1.
  - err_o=1 for the following cycle; code_o is unchanged.
  - ready_o stays 1, so a new transfer is possible in the very next cycle.
- Legal digit at transfer:
  - The encoded word is registered into the shift register and code_o.
  - State goes to START and ready_o=0, busy_o=1.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 5 bits MSB first (w7 first), each held CLKS_PER_BIT cycles. Bit index counts 0..4; after bit 4 expires, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing:
  - Bit counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - tx_o is registered; it changes on the edge that enters a bit.
  - Frame length is exactly 7*CLKS_PER_BIT cycles from the transfer edge to the edge returning to IDLE.
- End of frame:
  - On the edge entering IDLE: done_o=1 for one cycle, busy_o=0, ready_o=1.
  - A transfer in that same cycle starts the next start bit on the next edge, with no idle gap. Back-to-back frames are contiguous.
- Input protection: valid_i asserted while busy is ignored, because ready_o=0.
- Invariant: every transmitted data field contains exactly two ones.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-frame (after sending digit 5) -> tx_o=1, ready_o=1, code_o=00000 immediately; no done_o pulse.
- Single frame, CLKS_PER_BIT=4, digit 0:
  - tx_o sequence per 4-cycle slot is 0,1,1,0,0,0,1 and code_o=11000.
  - done_o pulses exactly 28 cycles after the transfer edge, and ready_o=1 in that cycle.
- All legal digits 0..9 sent in sequence:
  - A bench deserializer recovers each word and matches the table.
  - Each word has popcount 2, and the decoded digit equals the sent digit.
- Illegal digit 12:
  - err_o pulses for 1 cycle, tx_o stays 1, ready_o stays 1.
  - A following digit 7 in the next cycle sends 0,1,0,0,0,1,1.
- Back-to-back: valid_i held high with digits 3 then 8 -> second start bit begins on the cycle immediately after done_o. Total 56 cycles, with the 8 frame sending 0,1,0,0,1,0,1.
- Busy protection: toggle valid_i with digit 9 during a frame of digit 1 -> ignored; frame reads 0,0,0,0,1,1,1 and only one done_o pulse occurs.
